// File: rtl/pwr_est_pkg.sv
// Shared types and default widths for the power-estimation datapath.
// Used by the toggle monitor and the downstream weighting stage.
package pwr_est_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_WIN_W = 16;

endpackage

// File: rtl/toggle_cell.sv
// One monitored net: previous-value flop, saturating toggle counter, sticky saturation flag.
// Latency: count visible the cycle after the sampled edge; no backpressure (driven by the parent FSM).
// Exposes the raw toggle strobe only when TOGGLE_TOTAL_EN is defined.
module toggle_cell
  import pwr_est_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
`ifdef TOGGLE_TOTAL_EN
  , output logic           tog
`endif
);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             toggled;

  assign toggled = d ^ prev_q;

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    if (clr) begin
      // Capture the net so the first sample compares against the start-cycle value.
      prev_d = d;
      cnt_d  = '0;
      sat_d  = 1'b0;
    end else if (en) begin
      prev_d = d;
      if (toggled) begin
        if (&cnt_q) sat_d = 1'b1;
        else        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;
`ifdef TOGGLE_TOTAL_EN
  assign tog = toggled;
`endif

endmodule

// File: rtl/toggle_activity_counter.sv
// Per-net toggle counter over a programmable window; streams NUM_SIG results over valid/ready.
// Latency: first result win_len+1 cycles after accepted start; outputs hold while out_ready is low.
// TOGGLE_TOTAL_EN adds a window-wide toggle total; otherwise total_toggles is tied to 0.
module toggle_activity_counter
  import pwr_est_pkg::*;
#(
  parameter int NUM_SIG = 7,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int WIN_W   = DEF_WIN_W,
  parameter int IDX_W   = $clog2(NUM_SIG)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SIG-1:0]     sig_in,
  input  logic                   start,
  input  logic [WIN_W-1:0]       win_len,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_idx,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_last,
  output logic                   out_sat,
  output logic [CNT_W+IDX_W:0]   total_toggles
);

  localparam int TOT_W = CNT_W + IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SIG - 1);

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             vld_q, vld_d;
  logic             accept, sampling, at_last, hs;

  logic [CNT_W-1:0]   cnt_vec [NUM_SIG];
  logic [NUM_SIG-1:0] sat_vec;
`ifdef TOGGLE_TOTAL_EN
  logic [NUM_SIG-1:0] tog_vec;
`endif

  assign accept   = (state_q == IDLE) && start && (win_len != '0);
  assign sampling = (state_q == SAMPLE);
  assign at_last  = (idx_q == LAST_IDX);
  assign hs       = vld_q && out_ready;

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    vld_d     = vld_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SAMPLE;
          win_cnt_d = win_len;
          busy_d    = 1'b1;
        end
      end
      SAMPLE: begin
        win_cnt_d = win_cnt_q - WIN_W'(1);
        if (win_cnt_q == WIN_W'(1)) begin
          state_d = DRAIN;
          idx_d   = '0;
          vld_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (hs) begin
          if (at_last) begin
            state_d = IDLE;
            idx_d   = '0;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      vld_q     <= vld_d;
    end
  end

  for (genvar i = 0; i < NUM_SIG; i++) begin : g_cell
    toggle_cell #(.CNT_W(CNT_W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (sampling),
      .d     (sig_in[i]),
      .cnt   (cnt_vec[i]),
      .sat   (sat_vec[i])
`ifdef TOGGLE_TOTAL_EN
      , .tog (tog_vec[i])
`endif
    );
  end

`ifdef TOGGLE_TOTAL_EN
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [TOT_W-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_SIG; i++) pop = pop + TOT_W'(tog_vec[i]);
    tot_d = tot_q;
    if (accept)        tot_d = '0;
    else if (sampling) tot_d = tot_q + pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tot_q <= '0;
    else        tot_q <= tot_d;
  end

  assign total_toggles = tot_q;
`else
  assign total_toggles = '0;
`endif

  // Result fields read as zero outside DRAIN so idle outputs match the reset view.
  assign busy      = busy_q;
  assign out_valid = vld_q;
  assign out_idx   = idx_q;
  assign out_count = vld_q ? cnt_vec[idx_q] : '0;
  assign out_sat   = vld_q && sat_vec[idx_q];
  assign out_last  = vld_q && at_last;

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Directed bench for toggle_activity_counter: table-driven windows plus hand-written corner sequences.
module tb_toggle_activity_counter;

  localparam int NS = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  sig_in;
  logic        start;
  logic [15:0] win_len;
  logic        out_ready;

  logic        busy, out_valid, out_last, out_sat;
  logic [2:0]  out_idx;
  logic [15:0] out_count;
  logic [19:0] total_toggles;

  logic        s_busy, s_valid, s_last, s_sat;
  logic [2:0]  s_idx;
  logic [3:0]  s_count;
  logic [7:0]  s_total;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  toggle_activity_counter #(.NUM_SIG(7), .CNT_W(16), .WIN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .win_len(win_len),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_count(out_count), .out_last(out_last), .out_sat(out_sat),
    .total_toggles(total_toggles)
  );

  toggle_activity_counter #(.NUM_SIG(7), .CNT_W(4), .WIN_W(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .win_len(win_len),
    .busy(s_busy), .out_valid(s_valid), .out_ready(out_ready), .out_idx(s_idx),
    .out_count(s_count), .out_last(s_last), .out_sat(s_sat),
    .total_toggles(s_total)
  );

  typedef struct {
    int               win;
    logic [0:11][6:0] seq;
    logic [0:6][15:0] exp_cnt;
    int               exp_tot;
    int               stall_idx;
    int               stall_len;
    bit               mid_start;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] tot_exp(input int t);
`ifdef TOGGLE_TOTAL_EN
    return t;
`else
    return (t == 0) ? 0 : 0;
`endif
  endfunction

  task automatic chk_reset_view(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_idx"},   out_idx, 0);
    chk({tag, "_count"}, out_count, 0);
    chk({tag, "_last"},  out_last, 0);
    chk({tag, "_sat"},   out_sat, 0);
    chk({tag, "_total"}, total_toggles, 0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    sig_in    = v.seq[0];
    win_len   = 16'(v.win);
    start     = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= v.win; k++) begin
      chk($sformatf("v%0d_busy_s%0d", id, k), busy, 1);
      chk($sformatf("v%0d_valid_s%0d", id, k), out_valid, 0);
      sig_in = v.seq[k];
      start  = v.mid_start && (k == 2);
      if (v.mid_start && k == 2) win_len = 16'd2;
      step();
    end
    start = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (i == v.stall_idx) begin
        out_ready = 1'b0;
        for (int j = 0; j < v.stall_len; j++) begin
          chk($sformatf("v%0d_stall_valid", id), out_valid, 1);
          chk($sformatf("v%0d_stall_idx", id), out_idx, i);
          chk($sformatf("v%0d_stall_count", id), out_count, v.exp_cnt[i]);
          step();
        end
        out_ready = 1'b1;
      end
      chk($sformatf("v%0d_valid_%0d", id, i), out_valid, 1);
      chk($sformatf("v%0d_idx_%0d", id, i), out_idx, i);
      chk($sformatf("v%0d_count_%0d", id, i), out_count, v.exp_cnt[i]);
      chk($sformatf("v%0d_sat_%0d", id, i), out_sat, 0);
      chk($sformatf("v%0d_last_%0d", id, i), out_last, (i == NS - 1));
      chk($sformatf("v%0d_busy_d%0d", id, i), busy, 1);
      if (i == 0) chk($sformatf("v%0d_total", id), total_toggles, tot_exp(v.exp_tot));
      step();
    end
    chk($sformatf("v%0d_busy_end", id), busy, 0);
    chk($sformatf("v%0d_valid_end", id), out_valid, 0);
    chk($sformatf("v%0d_total_held", id), total_toggles, tot_exp(v.exp_tot));
  endtask

  initial begin
    vecs[0].win = 8;
    vecs[0].seq = {7'h00, 7'h01, 7'h40, 7'h41, 7'h40, 7'h01, 7'h00, 7'h01, 7'h00, 7'h00, 7'h00, 7'h00};
    vecs[0].exp_cnt = {16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd2};
    vecs[0].exp_tot = 10; vecs[0].stall_idx = -1; vecs[0].stall_len = 0; vecs[0].mid_start = 1'b0;

    vecs[1].win = 3;
    vecs[1].seq = {7'h7F, 7'h00, 7'h55, 7'h55, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    vecs[1].exp_cnt = {16'd2, 16'd1, 16'd2, 16'd1, 16'd2, 16'd1, 16'd2};
    vecs[1].exp_tot = 11; vecs[1].stall_idx = 2; vecs[1].stall_len = 3; vecs[1].mid_start = 1'b0;

    // 4:1 mux: bits a,b,c,d,sel0,sel1,out
    vecs[2].win = 6;
    vecs[2].seq = {7'h45, 7'h15, 7'h65, 7'h21, 7'h31, 7'h79, 7'h08, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    vecs[2].exp_cnt = {16'd1, 16'd0, 16'd1, 16'd1, 16'd4, 16'd2, 16'd5};
    vecs[2].exp_tot = 14; vecs[2].stall_idx = -1; vecs[2].stall_len = 0; vecs[2].mid_start = 1'b1;

    rst_n = 1'b0; sig_in = '0; start = 1'b0; win_len = '0; out_ready = 1'b1;
    #3;
    chk_reset_view("rst");
    step();
    rst_n = 1'b1;
    step();

    // start with win_len=0 is ignored
    start = 1'b1; win_len = 16'd0;
    step();
    start = 1'b0;
    chk("zero_win_busy0", busy, 0);
    step();
    chk("zero_win_busy1", busy, 0);
    chk("zero_win_valid", out_valid, 0);

    for (int n = 0; n < 3; n++) run_vec(vecs[n], n);

    // saturation on the CNT_W=4 instance
    sig_in = '0; win_len = 16'd20; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      sig_in = (k % 2 == 1) ? 7'h02 : 7'h00;
      step();
    end
    for (int i = 0; i < NS; i++) begin
      chk($sformatf("sat_valid_%0d", i), s_valid, 1);
      chk($sformatf("sat_idx_%0d", i), s_idx, i);
      chk($sformatf("sat_count_%0d", i), s_count, (i == 1) ? 15 : 0);
      chk($sformatf("sat_flag_%0d", i), s_sat, (i == 1));
      if (i == 1) begin
        chk("sat_wide_count", out_count, 20);
        chk("sat_wide_flag", out_sat, 0);
        chk("sat_total", s_total, tot_exp(20));
      end
      step();
    end
    chk("sat_busy_end", s_busy, 0);

    // reset mid-window
    sig_in = '0; win_len = 16'd10; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      sig_in = (k % 2 == 1) ? 7'h04 : 7'h00;
      step();
    end
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_view("midrst");
    chk("midrst_s_busy", s_busy, 0);
    step();
    rst_n = 1'b1;
    step();
    chk_reset_view("postrst");
    run_vec(vecs[1], 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_activity_counter.md
# toggle_activity_counter

Switching-activity monitor for the power estimation accelerator. Sits directly downstream of the gate-level DUT stimulus (e.g. the 4:1 mux: inputs a, b, c, d, sel[1:0] and output out, 7 nets). It samples a bundle of nets over a programmable window and counts per-net 0↔1 transitions. It then streams the per-net counts to the power-weighting stage over a valid/ready interface.

## Interface
- NUM_SIG, 7, number of monitored nets
- CNT_W, 16, per-net toggle counter width
- WIN_W, 16, window-length counter width
- IDX_W, $clog2(NUM_SIG), index width (derived)

- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- sig_in  in  NUM_SIG  monitored nets, already synchronous to clk
- start  in  1  single-cycle request to begin a window
- win_len  in  WIN_W  window length in cycles, sampled on accepted start
- busy  out  1  high from the cycle after accepted start until the last result handshake
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_idx  out  IDX_W  net index of current result
- out_count  out  CNT_W  toggle count of net out_idx
- out_last  out  1  marks result for index NUM_SIG-1
- out_sat  out  1  counter of net out_idx saturated during window
- total_toggles  out  CNT_W+IDX_W+1  sum of all toggles in last window (see Configuration)

## Operation
- FSM states: IDLE, SAMPLE, DRAIN.
- IDLE:
  - start=1 with win_len≠0 is accepted.
  - On acceptance: capture prev=sig_in, clear all counters and sat flags, load win_cnt=win_len, go to SAMPLE.
  - start with win_len=0 is ignored; FSM stays in IDLE.
- start is ignored in SAMPLE and DRAIN.
- SAMPLE, each cycle:
  - tog=sig_in^prev; prev<=sig_in.
  - Every net with tog[i]=1 increments its counter.
  - A counter at 2^CNT_W-1 holds its value and sets the sticky sat[i] instead of incrementing.
  - win_cnt decrements. When win_cnt reaches 1, that cycle is the last sample; the next state is DRAIN, with out_idx=0.
- DRAIN:
  - out_valid=1; out_count=cnt[out_idx]; out_sat=sat[out_idx]; out_last=(out_idx==NUM_SIG-1).
  - Handshake occurs on out_valid&&out_ready. On a handshake, out_idx increments.
  - A handshake with out_last=1 returns the FSM to IDLE.
  - While out_ready=0, all outputs hold stable.
- Counts are retained after DRAIN until the next accepted start.

## Timing
- Reset values: state=IDLE, busy=0, out_valid=0, out_idx=0, out_count=0, out_last=0, out_sat=0, total_toggles=0, all counters/prev/sat=0.
- Accepted start at cycle T:
  - busy=1 from T+1.
  - Samples taken in cycles T+1 … T+win_len.
  - out_valid=1 from T+win_len+1.
- A toggle at the transition into cycle T+1 (relative to the value at T) is counted.
- DRAIN, sustained out_ready=1: one result per cycle, NUM_SIG cycles total. busy falls the cycle after the final handshake.
- Back-to-back: start asserted in the cycle busy falls is accepted.
- rst_n assertion mid-window or mid-drain immediately forces reset values; no partial result is emitted.

## Configuration
- TOGGLE_TOTAL_EN defined:
  - total_toggles accumulates the popcount of tog each SAMPLE cycle. It is cleared on accepted start.
  - Width is wide enough never to saturate for NUM_SIG nets at CNT_W saturation.
  - Valid during DRAIN and held until the next accepted start.
- TOGGLE_TOTAL_EN undefined: the port still exists but is tied to 0, and the accumulator and popcount logic are absent.

## Structure
- Shared package pwr_est_pkg holds:
  - the state enum (IDLE/SAMPLE/DRAIN);
  - the default CNT_W/WIN_W constants, reused by the weighting stage.
- Sub-module toggle_cell is instantiated NUM_SIG times. Each holds one prev flop, a CNT_W saturating counter and a sticky sat flag. Inputs: clr, en, d.

## Test plan
- Stimulus: reset, start with win_len=8; net0 toggles every cycle, net6 toggles twice, others constant; out_ready=1.
  - Expected: out_valid at T+9; counts idx0=8, idx6=2, rest 0; out_last only on idx6; busy falls after 7 results.
- Backpressure: out_ready low for 3 cycles at idx2.
  - Expected: out_idx/out_count held; no index skipped or repeated.
- Saturation: CNT_W=4, win_len=20, net1 toggles every cycle.
  - Expected: count 15, out_sat=1 for idx1 only.
- Ignored starts:
  - start with win_len=0 → busy stays 0.
  - start during SAMPLE → window length unchanged.
- Reset mid-operation: rst_n pulsed low at sample cycle 4 of 10.
  - Expected: all outputs at reset values; a following start with win_len=3 produces correct fresh counts.
- TOGGLE_TOTAL_EN: mux sequence (7 nets, win_len=6).
  - Expected: total_toggles equals the sum of the 7 streamed counts.
  - Macro undefined: total_toggles stays 0.
